// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage issue controller for the 33-step iterative divider.
// Accepts one divide/modulo op, holds operands stable while the divider runs,
// captures the quotient or remainder and hands it downstream. A cancelled op is
// drained so the divider counter is back at 0 before the next op starts.
//
// Ports:
//   div_clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready        op handshake from EX (in_ready is combinational)
//   in_op                    00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//   in_src1/in_src2/in_dest  dividend, divisor, destination tag
//   cancel                   pipeline flush, highest priority
//   out_valid/out_ready      result handshake
//   out_result/out_dest      quotient or remainder and its tag
//   div_req/div_signed_o     divider request and sign mode
//   div_x/div_y              divider operands
//   div_s/div_r/div_complete divider quotient, remainder, completion
module div_issue_ctrl #(
    parameter int unsigned DEST_W = 5
) (
    input  logic              div_clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [31:0]       in_src1,
    input  logic [31:0]       in_src2,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              div_req,
    output logic              div_signed_o,
    output logic [31:0]       div_x,
    output logic [31:0]       div_y,
    input  logic [31:0]       div_s,
    input  logic [31:0]       div_r,
    input  logic              div_complete
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                signed_q, signed_d;
    logic                mod_q, mod_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                accept;

    // A new op may enter when idle, or when the held result leaves this cycle.
    assign in_ready = ~cancel & ((state_q == S_IDLE) |
                                 ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign out_valid    = (state_q == S_DONE);
    assign div_req      = (state_q == S_BUSY) | (state_q == S_DRAIN);
    assign div_x        = x_q;
    assign div_y        = y_q;
    assign div_signed_o = signed_q;
    assign out_result   = result_q;
    assign out_dest     = dest_q;

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        mod_d    = mod_q;
        dest_d   = dest_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_BUSY;
            end
            S_BUSY: begin
                // div_req stays high through the complete cycle so the
                // divider counter wraps to 0 on that edge.
                if (cancel) begin
                    state_d = div_complete ? S_IDLE : S_DRAIN;
                end else if (div_complete) begin
                    state_d  = S_DONE;
                    result_d = mod_q ? div_r : div_s;
                end
            end
            S_DONE: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    state_d = accept ? S_BUSY : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_complete) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            x_d      = in_src1;
            y_d      = in_src2;
            signed_d = ~in_op[1];
            mod_d    = in_op[0];
            dest_d   = in_dest;
        end
    end

    // State and operand registers.
    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            mod_q    <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            mod_q    <= mod_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl with a behavioural 33-step divider model and a
// result scoreboard checked by an independent monitor.
module tb_div_issue_ctrl;

    localparam int unsigned DEST_W = 5;

    logic              div_clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [31:0]       in_src1;
    logic [31:0]       in_src2;
    logic [DEST_W-1:0] in_dest;
    logic              cancel;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              div_req;
    logic              div_signed_o;
    logic [31:0]       div_x;
    logic [31:0]       div_y;
    logic [31:0]       div_s;
    logic [31:0]       div_r;
    logic              div_complete;

    div_issue_ctrl #(.DEST_W(DEST_W)) dut (
        .div_clk      (div_clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .in_dest      (in_dest),
        .cancel       (cancel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_dest     (out_dest),
        .div_req      (div_req),
        .div_signed_o (div_signed_o),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete)
    );

    always #5 div_clk = ~div_clk;

    int unsigned cyc = 0;
    always @(posedge div_clk) cyc <= cyc + 1;

    // Divider model: counter 0..33 while div_req, complete at 33, wraps to 0.
    logic [5:0] dcnt;
    always @(posedge div_clk) begin
        if (!resetn)      dcnt <= '0;
        else if (div_req) dcnt <= (dcnt == 6'd33) ? 6'd0 : dcnt + 6'd1;
    end

    always_comb begin
        div_s = '0;
        div_r = '0;
        if (div_y != 32'd0) begin
            if (div_signed_o) begin
                div_s = 32'($signed(div_x) / $signed(div_y));
                div_r = 32'($signed(div_x) % $signed(div_y));
            end else begin
                div_s = div_x / div_y;
                div_r = div_x % div_y;
            end
        end
        div_complete = div_req && (dcnt == 6'd33);
    end

    typedef struct {
        logic [31:0]       res;
        logic [DEST_W-1:0] dest;
        int unsigned       vcyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive an op and wait (bounded) for acceptance; acc is the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [DEST_W-1:0] d, input bit push,
                         input logic [31:0] exp_res, output int unsigned acc);
        bit ok = 0;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            @(negedge div_clk);
        end
        if (ok) begin
            acc = cyc + 1;
            if (push) q.push_back('{exp_res, d, acc + 34});
            @(negedge div_clk);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready never rose for dest %0d", d);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: scoreboard on handshakes, output stability, divider contract.
    initial begin
        bit                have_start = 0;
        int unsigned       start_cyc  = 0;
        logic [31:0]       prev_res   = '0;
        logic [DEST_W-1:0] prev_dest  = '0;
        logic              prev_req   = 1'b0;
        logic [31:0]       px = '0, py = '0;
        logic              ps = 1'b0;
        exp_t              e;
        forever begin
            @(negedge div_clk);
            #2;
            if (!resetn) begin
                have_start = 0;
                prev_req   = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!have_start) begin
                    have_start = 1;
                    start_cyc  = cyc;
                end else begin
                    check("hold_result", out_result, prev_res);
                    check("hold_dest", 32'(out_dest), 32'(prev_dest));
                end
                prev_res  = out_result;
                prev_dest = out_dest;
                if (out_ready && !cancel) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got 0x%08h dest %0d, expected none", out_result, out_dest);
                    end else begin
                        e = q.pop_front();
                        check("result", out_result, e.res);
                        check("dest", 32'(out_dest), 32'(e.dest));
                        check("latency", 32'(start_cyc), 32'(e.vcyc));
                    end
                    have_start = 0;
                end
            end else begin
                have_start = 0;
            end
            if (div_req) begin
                if (!prev_req) begin
                    check("div_cnt_start", 32'(dcnt), 32'd0);
                end else begin
                    check("x_stable", div_x, px);
                    check("y_stable", div_y, py);
                    check("sign_stable", 32'(div_signed_o), 32'(ps));
                end
            end
            prev_req = div_req;
            px = div_x; py = div_y; ps = div_signed_o;
        end
    end

    // Directed stimulus.
    initial begin
        int unsigned acc;
        bit          seen;
        resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
        in_dest = '0; cancel = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge div_clk);
        resetn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_div_req", 32'(div_req), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_dest", 32'(out_dest), 32'd0);
        check("rst_div_x", div_x, 32'd0);
        check("rst_div_y", div_y, 32'd0);
        check("rst_signed", 32'(div_signed_o), 32'd0);
        @(negedge div_clk);

        // Basic ops.
        issue(2'b10, 32'd100, 32'd7, 5'd3, 1, 32'h0000000E, acc);
        check("divwu_signed", 32'(div_signed_o), 32'd0);
        repeat (40) @(negedge div_clk);
        issue(2'b11, 32'd100, 32'd7, 5'd4, 1, 32'h00000002, acc);
        repeat (40) @(negedge div_clk);
        issue(2'b00, 32'hFFFFFFF9, 32'd2, 5'd5, 1, 32'hFFFFFFFD, acc);
        check("divw_signed", 32'(div_signed_o), 32'd1);
        repeat (40) @(negedge div_clk);
        issue(2'b01, 32'hFFFFFFF9, 32'd2, 5'd6, 1, 32'hFFFFFFFF, acc);
        repeat (40) @(negedge div_clk);

        // Backpressure then back-to-back accept.
        out_ready = 1'b0;
        issue(2'b10, 32'd20, 32'd4, 5'd7, 1, 32'h00000005, acc);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (out_valid) begin seen = 1; break; end
            @(negedge div_clk);
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        @(negedge div_clk);
        in_valid = 1'b1; in_op = 2'b10; in_src1 = 32'd9; in_src2 = 32'd3; in_dest = 5'd8;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge div_clk);
        end
        out_ready = 1'b1;
        issue(2'b10, 32'd9, 32'd3, 5'd8, 1, 32'h00000003, acc);
        repeat (40) @(negedge div_clk);

        // Cancel in BUSY: drain, then next op with exact latency.
        issue(2'b10, 32'd1000, 32'd10, 5'd9, 0, 32'd0, acc);
        repeat (9) @(negedge div_clk);
        cancel = 1'b1;
        #1;
        check("cancel_busy_req", 32'(div_req), 32'd1);
        @(negedge div_clk);
        cancel = 1'b0;
        in_valid = 1'b1; in_op = 2'b10; in_src1 = 32'd50; in_src2 = 32'd5; in_dest = 5'd10;
        while (cyc < acc + 34) begin
            #1;
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("drain_div_req", 32'(div_req), 32'd1);
            @(negedge div_clk);
        end
        #1;
        check("drain_end_req", 32'(div_req), 32'd0);
        check("drain_end_valid", 32'(out_valid), 32'd0);
        issue(2'b10, 32'd50, 32'd5, 5'd10, 1, 32'h0000000A, acc);
        repeat (40) @(negedge div_clk);

        // Cancel on the complete cycle.
        issue(2'b10, 32'd1000, 32'd10, 5'd11, 0, 32'd0, acc);
        repeat (33) @(negedge div_clk);
        cancel = 1'b1;
        #1;
        check("cc_complete", 32'(div_complete), 32'd1);
        @(negedge div_clk);
        cancel = 1'b0;
        #1;
        check("cc_out_valid", 32'(out_valid), 32'd0);
        check("cc_div_req", 32'(div_req), 32'd0);
        check("cc_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge div_clk);

        // Cancel while DONE.
        out_ready = 1'b0;
        issue(2'b10, 32'd77, 32'd7, 5'd12, 0, 32'd0, acc);
        repeat (34) @(negedge div_clk);
        #1;
        check("cd_valid_before", 32'(out_valid), 32'd1);
        cancel = 1'b1;
        @(negedge div_clk);
        cancel = 1'b0;
        #1;
        check("cd_out_valid", 32'(out_valid), 32'd0);
        check("cd_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge div_clk);

        // Reset mid-operation, then a fresh op.
        issue(2'b10, 32'd1000, 32'd10, 5'd14, 0, 32'd0, acc);
        repeat (19) @(negedge div_clk);
        resetn = 1'b0;
        @(negedge div_clk);
        resetn = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_div_req", 32'(div_req), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_div_x", div_x, 32'd0);
        check("mr_out_dest", 32'(out_dest), 32'd0);
        @(negedge div_clk);
        issue(2'b00, 32'hFFFFFF9C, 32'd7, 5'd13, 1, 32'hFFFFFFF2, acc);
        repeat (40) @(negedge div_clk);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
